// File: rtl/hub75_capture.sv
// hub75_capture: samples a HUB75 panel bus and replays each latched row bitplane as a pixel write stream.
module hub75_capture #(
    parameter int X_BITS     = 6,
    parameter int ADDR_PINS  = 5,
    parameter int PLANE_BITS = 4,
    parameter int ON_BITS    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  led_clk,
    input  logic                  latch,
    input  logic                  enable_n,
    input  logic                  r_in,
    input  logic                  g_in,
    input  logic                  b_in,
    input  logic [ADDR_PINS-1:0]  led_addr,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [X_BITS-1:0]     wr_x,
    output logic [ADDR_PINS-1:0]  wr_y,
    output logic [PLANE_BITS-1:0] wr_plane,
    output logic [2:0]            wr_rgb,
    output logic [ON_BITS-1:0]    on_time,
    output logic                  short_row,
    output logic                  long_row,
    output logic                  overrun
);
    localparam int WIDTH = 1 << X_BITS;
    localparam int SW = ADDR_PINS + 6;
    localparam logic [SW-1:0] IDLE_PINS = SW'(4);

    typedef enum logic {IDLE, DRAIN} state_t;
    state_t state, state_nxt;

    logic [SW-1:0] s1, s2;
    logic clk_d, lat_d;
    logic shift_rise, lat_rise, lat_fall, en, commit, armed, seen;
    logic [2:0] pix;
    logic [ADDR_PINS-1:0] addr, last_addr;
    logic [WIDTH-1:0][2:0] shift_buf, shift_nxt, hold_buf;
    logic [X_BITS:0] bit_cnt, cnt_nxt;
    logic [ON_BITS-1:0] on_cnt, on_nxt;
    logic [PLANE_BITS-1:0] plane_cnt, plane_nxt;

    // Bus layout: {addr, r, g, b, enable_n, latch, led_clk}; enable_n idles high
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= IDLE_PINS;
            s2 <= IDLE_PINS;
            clk_d <= 1'b0;
            lat_d <= 1'b0;
        end else begin
            s1 <= {led_addr, r_in, g_in, b_in, enable_n, latch, led_clk};
            s2 <= s1;
            clk_d <= s2[0];
            lat_d <= s2[1];
        end
    end

    always_comb begin
        shift_rise = s2[0] & ~clk_d;
        lat_rise = s2[1] & ~lat_d;
        lat_fall = ~s2[1] & lat_d;
        en = ~s2[2];
        pix = s2[5:3];
        addr = s2[SW-1:6];
        commit = lat_fall & armed;
        shift_nxt = shift_buf;
        cnt_nxt = bit_cnt;
        // A shift landing in the commit cycle still belongs to the committed row
        if (shift_rise && !bit_cnt[X_BITS]) begin
            shift_nxt[bit_cnt[X_BITS-1:0]] = pix;
            cnt_nxt = bit_cnt + 1'b1;
        end
        on_nxt = (en && on_cnt != '1) ? on_cnt + 1'b1 : on_cnt;
        plane_nxt = (seen && addr == last_addr) ? plane_cnt + 1'b1 : '0;
        state_nxt = state;
        if (state == IDLE && commit)
            state_nxt = DRAIN;
        else if (state == DRAIN && wr_ready && wr_x == '1)
            state_nxt = IDLE;
        wr_valid = state == DRAIN;
        wr_rgb = wr_valid ? hold_buf[wr_x] : 3'b000;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_buf <= '0;
            hold_buf <= '0;
            bit_cnt <= '0;
            on_cnt <= '0;
            armed <= 1'b0;
            seen <= 1'b0;
            last_addr <= '0;
            plane_cnt <= '0;
            wr_x <= '0;
            wr_y <= '0;
            wr_plane <= '0;
            on_time <= '0;
            short_row <= 1'b0;
            long_row <= 1'b0;
            overrun <= 1'b0;
        end else begin
            shift_buf <= commit ? '0 : shift_nxt;
            bit_cnt <= commit ? '0 : cnt_nxt;
            on_cnt <= commit ? '0 : on_nxt;
            armed <= commit ? 1'b0 : (lat_rise ? 1'b1 : armed);
            long_row <= long_row | (shift_rise & bit_cnt[X_BITS]);
            wr_x <= (state == DRAIN && wr_ready) ? wr_x + 1'b1 : wr_x;
            if (commit) begin
                short_row <= short_row | ~cnt_nxt[X_BITS];
                seen <= 1'b1;
                last_addr <= addr;
                plane_cnt <= plane_nxt;
                // A row committed while the previous one drains is dropped
                if (state == IDLE) begin
                    hold_buf <= shift_nxt;
                    wr_y <= addr;
                    wr_plane <= plane_nxt;
                    on_time <= on_cnt;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_hub75_capture.sv
// tb_hub75_capture: random HUB75 rows against a row-level reference model with a beat scoreboard.
module tb_hub75_capture;
    logic clk = 0, reset = 1, led_clk = 0, latch = 0, enable_n = 1;
    logic r_in = 0, g_in = 0, b_in = 0, wr_ready = 0;
    logic [4:0] led_addr = 0;
    logic wr_valid, short_row, long_row, overrun;
    logic [5:0] wr_x;
    logic [4:0] wr_y;
    logic [3:0] wr_plane;
    logic [2:0] wr_rgb;
    logic [15:0] on_time;

    hub75_capture dut (
        .clk(clk), .reset(reset), .led_clk(led_clk), .latch(latch), .enable_n(enable_n),
        .r_in(r_in), .g_in(g_in), .b_in(b_in), .led_addr(led_addr),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
        .wr_plane(wr_plane), .wr_rgb(wr_rgb), .on_time(on_time),
        .short_row(short_row), .long_row(long_row), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {int x; int y; int plane; int rgb; int on;} beat_t;
    beat_t exp_q[$];
    int vecs = 0, fails = 0, mode = 1;
    logic [2:0] row[64];
    int cnt = 0, m_plane = 0, m_last = 0;
    bit m_seen = 0, m_short = 0, m_long = 0, m_over = 0;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h", n, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Ready: 0 = held low, 1 = random, 2 = held high
    initial forever begin
        @(posedge clk);
        #2;
        wr_ready = (mode == 0) ? 1'b0 : (mode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
        if (!reset && wr_valid && wr_ready) begin
            vecs++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_beat got x=%0d y=%0d", wr_x, wr_y);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                if ({wr_x, wr_y, wr_plane, wr_rgb} !== {6'(e.x), 5'(e.y), 4'(e.plane), 3'(e.rgb)}) begin
                    fails++;
                    $display("FAIL beat got x=%0d y=%0d p=%0d rgb=%b expected x=%0d y=%0d p=%0d rgb=%b",
                             wr_x, wr_y, wr_plane, wr_rgb, e.x, e.y, e.plane, 3'(e.rgb));
                end
                if (e.x == 0) begin
                    vecs++;
                    if (on_time !== 16'(e.on)) begin
                        fails++;
                        $display("FAIL on_time got=%0d expected=%0d", on_time, e.on);
                    end
                end
            end
        end
    end

    task automatic shift(input logic [2:0] p);
        {r_in, g_in, b_in} = p;
        led_clk = 0;
        tick(3);
        led_clk = 1;
        tick(3);
        led_clk = 0;
        if (cnt < 64) row[cnt] = p;
        else m_long = 1;
        cnt++;
    endtask

    task automatic shift_row(input int n, input int hot);
        for (int i = 0; i < n; i++)
            shift(hot < 0 ? 3'($urandom_range(0, 7)) : (i == hot ? 3'b100 : 3'b000));
    endtask

    task automatic latch_row(input int a, input int on_n, input bit busy);
        led_addr = 5'(a);
        if (on_n > 0) begin
            enable_n = 0;
            tick(on_n);
            enable_n = 1;
        end
        tick(2);
        if (cnt < 64) m_short = 1;
        m_plane = (m_seen && a == m_last) ? (m_plane + 1) % 16 : 0;
        m_seen = 1;
        m_last = a;
        if (busy) m_over = 1;
        else for (int x = 0; x < 64; x++) exp_q.push_back('{x, a, m_plane, int'(row[x]), on_n});
        for (int x = 0; x < 64; x++) row[x] = 3'b000;
        cnt = 0;
        latch = 1;
        tick(3);
        latch = 0;
        tick(4);
    endtask

    task automatic check_flags;
        chk("short_row", short_row, m_short);
        chk("long_row", long_row, m_long);
        chk("overrun", overrun, m_over);
    endtask

    task automatic wait_drain;
        int n = 0;
        while ((exp_q.size() != 0 || wr_valid) && n < 3000) begin
            tick(1);
            n++;
        end
        chk("drain_timeout", n < 3000, 1);
        check_flags();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        for (int x = 0; x < 64; x++) row[x] = 3'b000;
        tick(4);
        reset = 0;
        tick(1);
        chk("reset_valid", wr_valid, 0);
        chk("reset_x", wr_x, 0);
        chk("reset_on_time", on_time, 0);
        check_flags();
        shift_row(64, 5);
        latch_row(3, 0, 0);
        wait_drain();
        for (int i = 0; i < 11; i++) begin
            shift_row(64, -1);
            latch_row(7, $urandom_range(0, 30), 0);
            wait_drain();
        end
        shift_row(64, -1);
        latch_row(8, 0, 0);
        wait_drain();
        for (int i = 0; i < 16; i++) begin
            n = $urandom_range(0, 5);
            shift_row(n == 0 ? 58 : n == 1 ? 67 : 64, -1);
            latch_row($urandom_range(0, 2), $urandom_range(0, 40), 0);
            wait_drain();
        end
        mode = 2;
        shift_row(64, -1);
        latch_row(4, 100, 0);
        n = 0;
        while (!(wr_valid && wr_x == 20) && n < 500) begin
            tick(1);
            n++;
        end
        chk("stall_reach_timeout", n < 500, 1);
        mode = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("stall_valid", wr_valid, 1);
            chk("stall_x", wr_x, 20);
        end
        mode = 1;
        wait_drain();
        shift_row(40, -1);
        latch_row(4, 0, 0);
        wait_drain();
        shift_row(70, -1);
        latch_row(5, 0, 0);
        wait_drain();
        mode = 0;
        shift_row(64, -1);
        latch_row(6, 0, 0);
        latch_row(6, 0, 1);
        mode = 1;
        wait_drain();
        shift_row(64, -1);
        latch_row(9, 0, 0);
        n = 0;
        while (!(wr_valid && wr_x >= 10) && n < 500) begin
            tick(1);
            n++;
        end
        chk("mid_drain_timeout", n < 500, 1);
        reset = 1;
        tick(1);
        reset = 0;
        exp_q.delete();
        m_seen = 0;
        m_short = 0;
        m_long = 0;
        m_over = 0;
        chk("rst_valid", wr_valid, 0);
        chk("rst_x", wr_x, 0);
        chk("rst_y", wr_y, 0);
        chk("rst_plane", wr_plane, 0);
        chk("rst_rgb", wr_rgb, 0);
        chk("rst_on_time", on_time, 0);
        check_flags();
        shift_row(64, -1);
        latch_row(9, 12, 0);
        wait_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule
